deja_glitch_sweep: RTL and testbench
====================================

DEJA_GLITCH_SWEEP -- requirements
Module: deja_glitch_sweep

Interface
REQ-001 SHALL have parameter ADR_OFS, default 4'h0: glitch-power register address for glitch offset.
REQ-002 SHALL have parameter ADR_WID, default 4'h1: glitch-power register address for glitch width.
REQ-003 SHALL have parameter TIMEOUT, default 16: bus-ack timeout in cycles, used only under DEJA_SWEEP_TIMEOUT_EN.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start_i, input, 1: start a sweep when sampled high in IDLE.
REQ-007 SHALL have port abort_i, input, 1: cancel an active sweep.
REQ-008 SHALL have ports first_i, last_i, step_i, input, 8 each: sweep offset range and increment.
REQ-009 SHALL have port width_i, input, 8: glitch width written to the glitch-power block.
REQ-010 SHALL have ports run_len_i and gap_len_i, input, 8 each: run-high cycles and idle cycles per attempt.
REQ-011 SHALL have ports m_stb_o, output, 1; m_we_o, output, 1; m_adr_o, output, 4; m_dat_o, output, 8; m_ack_i, input, 1: bus master to the glitch-power register port.
REQ-012 SHALL have port run_o, output, 1: drives the glitch-power run input.
REQ-013 SHALL have ports busy_o, output, 1; done_o, output, 1; err_o, output, 1: sweep status.
REQ-014 SHALL have ports cur_o, output, 8 (current offset) and count_o, output, 8 (attempts completed).

Function
REQ-015 SHALL implement states IDLE, WR_WID, WR_OFS, RUN, GAP, NEXT.
REQ-016 SHALL, on start_i high in IDLE, latch all config inputs and load cur_o=first_i and count_o=0; config input changes mid-sweep have no effect.
REQ-017 SHALL, when first_i > last_i at start, perform no bus or run activity, pulse done_o on the next cycle and keep count_o=0.
REQ-018 SHALL otherwise enter WR_WID: m_stb_o=1, m_we_o=1, m_adr_o=ADR_WID, m_dat_o=width, asserted from the cycle after start.
REQ-019 SHALL hold m_stb_o, m_adr_o and m_dat_o stable until m_ack_i is sampled high, and drop m_stb_o on the following cycle.
REQ-020 SHALL, after the WR_WID ack, enter WR_OFS and write cur_o to ADR_OFS with the same handshake.
REQ-021 SHALL, after the WR_OFS ack, enter RUN with run_o high for exactly max(run_len,1) cycles.
REQ-022 SHALL enter GAP with run_o low for exactly gap_len cycles (zero cycles allowed) and increment count_o, saturating at 255.
REQ-023 SHALL, in NEXT, compute cur+max(step,1) at 9 bits; a result > last or > 255 ends the sweep, otherwise cur_o updates and the FSM returns to WR_OFS.
REQ-024 SHALL, on sweep end, pulse done_o for one cycle and return to IDLE; cur_o and count_o hold their final values.
REQ-025 SHALL drive busy_o high in every state except IDLE.
REQ-026 SHALL ignore start_i while busy_o is high.
REQ-027 SHALL, on abort_i high in any non-IDLE state, drive m_stb_o and run_o low on the next cycle and go to IDLE, without pulsing done_o or setting err_o.
REQ-028 SHALL give abort_i priority over the completion of the current state when both occur in the same cycle.
REQ-029 SHALL hold m_we_o=1 whenever m_stb_o=1; the block never issues reads.

Reset
REQ-030 SHALL, on rst_i high, enter IDLE at the next edge with all outputs 0, including cur_o, count_o and err_o.
REQ-031 SHALL, on rst_i during a sweep, drop m_stb_o and run_o immediately at that edge, with no done_o pulse.

Configuration
REQ-032 SHALL, with DEJA_SWEEP_TIMEOUT_EN defined, count cycles while m_stb_o is high and m_ack_i is low; on reaching TIMEOUT it SHALL drop m_stb_o, set err_o and go to IDLE without a done_o pulse.
REQ-033 SHALL, with DEJA_SWEEP_TIMEOUT_EN defined, clear err_o on the next accepted start_i or on reset.
REQ-034 SHALL, without DEJA_SWEEP_TIMEOUT_EN, wait for m_ack_i indefinitely and hold err_o at 0.

Verification
REQ-035 Basic sweep: first=2, last=6, step=2, width=3, run_len=4, gap=2, ack after 1 cycle -> bus writes (1,3),(0,2),(0,4),(0,6); three 4-cycle run_o pulses; count_o=3; cur_o=6; one done_o pulse.
REQ-036 Empty range: first=9, last=5 -> no m_stb_o; done_o pulses 1 cycle after start; count_o=0.
REQ-037 Overflow: first=250, last=255, step=10 -> one attempt at offset 250; done_o pulses; count_o=1.
REQ-038 Abort: abort_i asserted on the 2nd run_o cycle of attempt 2 -> run_o low on the next cycle; busy_o low; no done_o; count_o=1.
REQ-039 Stalled ack: m_ack_i held low, macro defined, TIMEOUT=16 -> m_stb_o drops after 16 cycles and err_o=1; macro undefined -> m_stb_o stays high for 100+ cycles.
REQ-040 Reset and restart: rst_i pulsed mid-WR_OFS -> all outputs 0; a new start with step=0 behaves as step=1.

Source files
------------

// File: rtl/deja_glitch_sweep.sv
// rtl/deja_glitch_sweep.sv - glitch offset sweep sequencer driving a glitch-power register port
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, abort_i             begin a sweep from IDLE / cancel an active sweep
//   first_i, last_i, step_i      offset range and increment (step 0 acts as 1)
//   width_i                      glitch width written once per sweep
//   run_len_i, gap_len_i         run-high cycles (0 acts as 1) and idle cycles per attempt
//   m_stb_o, m_we_o, m_adr_o,
//   m_dat_o, m_ack_i             write-only bus master to the glitch-power registers
//   run_o                        glitch-power run strobe
//   busy_o, done_o, err_o        status: active, one-cycle completion pulse, bus timeout
//   cur_o, count_o               current offset, attempts completed (saturating)
//
// Build option: DEJA_SWEEP_TIMEOUT_EN enables the bus-ack timeout (TIMEOUT cycles).

module deja_glitch_sweep #(
  parameter logic [3:0]  ADR_OFS = 4'h0,
  parameter logic [3:0]  ADR_WID = 4'h1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] first_i,
  input  logic [7:0] last_i,
  input  logic [7:0] step_i,
  input  logic [7:0] width_i,
  input  logic [7:0] run_len_i,
  input  logic [7:0] gap_len_i,
  output logic       m_stb_o,
  output logic       m_we_o,
  output logic [3:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic       m_ack_i,
  output logic       run_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] cur_o,
  output logic [7:0] count_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_WID = 3'd1,
    WR_OFS = 3'd2,
    RUN    = 3'd3,
    GAP    = 3'd4,
    NEXT   = 3'd5
  } state_t;

  state_t     state, state_nx;

  logic [7:0] cur_q, count_q, cnt_q;
  logic [7:0] last_q, step_q, width_q, run_len_q, gap_len_q;
  logic       done_q;
  // One dead bus cycle after the width write is acked, so the strobe
  // visibly drops before the offset write begins.
  logic       rest_q;

  logic       stb;
  logic       abort_act;
  logic       timeout_hit;
  logic [7:0] step_eff;
  logic [8:0] next_sum;
  logic       next_end;

  assign stb       = (state == WR_WID) || ((state == WR_OFS) && !rest_q);
  assign abort_act = abort_i && (state != IDLE);
  assign step_eff  = (step_q == 8'd0) ? 8'd1 : step_q;
  // 9-bit sum so a wrap past 255 also ends the sweep.
  assign next_sum  = {1'b0, cur_q} + {1'b0, step_eff};
  assign next_end  = next_sum > {1'b0, last_q};

  always_comb begin
    state_nx = state;
    m_stb_o  = stb;
    m_we_o   = stb;
    m_adr_o  = 4'h0;
    m_dat_o  = 8'h00;
    run_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_nx = (first_i > last_i) ? IDLE : WR_WID;
      end
      WR_WID: begin
        m_adr_o = ADR_WID;
        m_dat_o = width_q;
        if (m_ack_i) state_nx = WR_OFS;
      end
      WR_OFS: begin
        m_adr_o = ADR_OFS;
        m_dat_o = cur_q;
        if (stb && m_ack_i) state_nx = RUN;
      end
      RUN: begin
        run_o = 1'b1;
        if (cnt_q == 8'd0) state_nx = (gap_len_q == 8'd0) ? NEXT : GAP;
      end
      GAP: begin
        if (cnt_q == 8'd0) state_nx = NEXT;
      end
      NEXT: begin
        state_nx = next_end ? IDLE : WR_OFS;
      end
      default: state_nx = IDLE;
    endcase
    if (timeout_hit) state_nx = IDLE;
    // Abort wins over whatever the current state was about to complete.
    if (abort_act) state_nx = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cur_q     <= 8'd0;
      count_q   <= 8'd0;
      cnt_q     <= 8'd0;
      last_q    <= 8'd0;
      step_q    <= 8'd0;
      width_q   <= 8'd0;
      run_len_q <= 8'd0;
      gap_len_q <= 8'd0;
      done_q    <= 1'b0;
      rest_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      if (abort_act) begin
        rest_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            rest_q <= 1'b0;
            if (start_i) begin
              cur_q     <= first_i;
              count_q   <= 8'd0;
              last_q    <= last_i;
              step_q    <= step_i;
              width_q   <= width_i;
              run_len_q <= run_len_i;
              gap_len_q <= gap_len_i;
              done_q    <= (first_i > last_i);
            end
          end
          WR_WID: begin
            if (m_ack_i) rest_q <= 1'b1;
          end
          WR_OFS: begin
            rest_q <= 1'b0;
            if (stb && m_ack_i)
              cnt_q <= (run_len_q == 8'd0) ? 8'd0 : run_len_q - 8'd1;
          end
          RUN: begin
            if (cnt_q == 8'd0) begin
              if (count_q != 8'hFF) count_q <= count_q + 8'd1;
              cnt_q <= gap_len_q - 8'd1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          GAP: begin
            cnt_q <= cnt_q - 8'd1;
          end
          NEXT: begin
            if (next_end) done_q <= 1'b1;
            else          cur_q  <= next_sum[7:0];
          end
          default: rest_q <= 1'b0;
        endcase
      end
    end
  end

`ifdef DEJA_SWEEP_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        err_q;

  assign timeout_hit = stb && !m_ack_i && (to_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      if (stb && !m_ack_i && !abort_act && !timeout_hit) to_cnt <= to_cnt + 16'd1;
      else                                               to_cnt <= 16'd0;
      if ((state == IDLE) && start_i)   err_q <= 1'b0;
      else if (timeout_hit && !abort_act) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  assign busy_o  = (state != IDLE);
  assign done_o  = done_q;
  assign cur_o   = cur_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_deja_glitch_sweep.sv
// tb/tb_deja_glitch_sweep.sv - scoreboard bench for deja_glitch_sweep

module tb_deja_glitch_sweep;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [7:0] first_i = '0, last_i = '0, step_i = '0, width_i = '0;
  logic [7:0] run_len_i = '0, gap_len_i = '0;
  logic       m_stb_o, m_we_o, m_ack_i = 1'b0;
  logic [3:0] m_adr_o;
  logic [7:0] m_dat_o;
  logic       run_o, busy_o, done_o, err_o;
  logic [7:0] cur_o, count_o;

  always #5 clk = ~clk;

  deja_glitch_sweep #(.ADR_OFS(4'h0), .ADR_WID(4'h1), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .first_i(first_i), .last_i(last_i), .step_i(step_i), .width_i(width_i),
    .run_len_i(run_len_i), .gap_len_i(gap_len_i),
    .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_ack_i(m_ack_i), .run_o(run_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .cur_o(cur_o), .count_o(count_o)
  );

  int n_cmp = 0, n_err = 0;
  logic [11:0] wr_q[$];
  int run_q[$];
  int done_cnt = 0, stb_cnt = 0, run_cnt = 0, runs_seen = 0;
  int ack_dly = 1, ack_wait = 0;
  bit ack_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bus slave: acks a strobe after ack_dly waiting cycles, single-cycle ack.
  always @(posedge clk) begin
    #1;
    if (ack_stall || m_stb_o !== 1'b1 || m_ack_i) begin
      m_ack_i  = 1'b0;
      ack_wait = 0;
    end else if (ack_wait >= ack_dly) begin
      m_ack_i  = 1'b1;
      ack_wait = 0;
    end else begin
      ack_wait++;
    end
  end

  always @(negedge clk) begin : mon
    logic [11:0] e;
    if (done_o === 1'b1) done_cnt++;
    if (m_stb_o === 1'b1) stb_cnt++;
    if (m_stb_o === 1'b1 && m_ack_i) begin
      chk("we_on_stb", m_we_o, 1);
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        e = wr_q.pop_front();
        chk("wr_adr", m_adr_o, e[11:8]);
        chk("wr_dat", m_dat_o, e[7:0]);
      end
    end
    if (run_o === 1'b1) run_cnt++;
    else if (run_cnt > 0) begin
      if (run_q.size() == 0) chk("run_unexpected", 1, 0);
      else chk("run_len", run_cnt, run_q.pop_front());
      run_cnt = 0;
      runs_seen++;
    end
  end

  task automatic start_sweep(input logic [7:0] f, l, s, w, rl, gl);
    @(negedge clk);
    first_i = f; last_i = l; step_i = s; width_i = w;
    run_len_i = rl; gap_len_i = gl;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait_expired", (n >= budget), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end

  initial begin
    int d0, s0, rs0, n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_stb", m_stb_o, 0);
    chk("rst_run", run_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cur", cur_o, 0);
    chk("rst_count", count_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    // Basic sweep 2..6 step 2; config changes mid-sweep must be ignored
    push_wr(4'h1, 8'd3); push_wr(4'h0, 8'd2); push_wr(4'h0, 8'd4); push_wr(4'h0, 8'd6);
    run_q.push_back(4); run_q.push_back(4); run_q.push_back(4);
    d0 = done_cnt;
    start_sweep(8'd2, 8'd6, 8'd2, 8'd3, 8'd4, 8'd2);
    chk("t1_stb_first_cycle", m_stb_o, 1);
    chk("t1_busy", busy_o, 1);
    first_i = 8'd0; last_i = 8'd0; step_i = 8'd7; width_i = 8'hEE;
    run_len_i = 8'd9; gap_len_i = 8'd9;
    wait_idle(500);
    chk("t1_count", count_o, 3);
    chk("t1_cur", cur_o, 6);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_wr_left", wr_q.size(), 0);
    chk("t1_run_left", run_q.size(), 0);

    // Empty range
    d0 = done_cnt;
    s0 = stb_cnt;
    start_sweep(8'd9, 8'd5, 8'd1, 8'd1, 8'd1, 8'd1);
    chk("t2_done_next_cycle", done_o, 1);
    chk("t2_busy", busy_o, 0);
    repeat (3) @(negedge clk);
    chk("t2_no_stb", stb_cnt - s0, 0);
    chk("t2_count", count_o, 0);
    chk("t2_done_pulses", done_cnt - d0, 1);

    // Overflow past 255 ends after one attempt
    push_wr(4'h1, 8'd7); push_wr(4'h0, 8'd250);
    run_q.push_back(2);
    d0 = done_cnt;
    start_sweep(8'd250, 8'd255, 8'd10, 8'd7, 8'd2, 8'd1);
    wait_idle(200);
    chk("t3_count", count_o, 1);
    chk("t3_cur", cur_o, 250);
    chk("t3_done_pulses", done_cnt - d0, 1);
    chk("t3_wr_left", wr_q.size(), 0);

    // Abort on the 2nd run cycle of attempt 2
    push_wr(4'h1, 8'd5); push_wr(4'h0, 8'd0); push_wr(4'h0, 8'd5);
    run_q.push_back(4); run_q.push_back(2);
    d0 = done_cnt;
    rs0 = runs_seen;
    start_sweep(8'd0, 8'd20, 8'd5, 8'd5, 8'd4, 8'd1);
    n = 0;
    while (!(runs_seen == rs0 + 1 && run_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_attempt2_wait_expired", (n >= 200), 0);
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("t4_run_low", run_o, 0);
    chk("t4_busy_low", busy_o, 0);
    chk("t4_stb_low", m_stb_o, 0);
    repeat (3) @(negedge clk);
    chk("t4_count", count_o, 1);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_err", err_o, 0);
    chk("t4_wr_left", wr_q.size(), 0);
    chk("t4_run_left", run_q.size(), 0);

    // Stalled ack
    ack_stall = 1'b1;
    d0 = done_cnt;
    start_sweep(8'd0, 8'd3, 8'd1, 8'd1, 8'd1, 8'd1);
    n = 0;
    while (m_stb_o && n < 120) begin
      @(negedge clk);
      n++;
    end
`ifdef DEJA_SWEEP_TIMEOUT_EN
    chk("t5_stb_cycles", n, 16);
    chk("t5_err", err_o, 1);
    chk("t5_busy", busy_o, 0);
    chk("t5_no_done", done_cnt - d0, 0);
`else
    chk("t5_stb_held", n, 120);
    chk("t5_err", err_o, 0);
    chk("t5_busy", busy_o, 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("t5_abort_idle", busy_o, 0);
`endif
    ack_stall = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-WR_OFS, then restart with step=0
    push_wr(4'h1, 8'd6);
    d0 = done_cnt;
    start_sweep(8'd1, 8'd3, 8'd0, 8'd6, 8'd0, 8'd0);
    chk("t6_err_cleared_on_start", err_o, 0);
    n = 0;
    while (!(m_stb_o && m_adr_o == 4'h0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_wr_ofs_wait_expired", (n >= 50), 0);
    rst_i = 1'b1;
    @(negedge clk);
    chk("t6_rst_stb", m_stb_o, 0);
    chk("t6_rst_run", run_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_cur", cur_o, 0);
    chk("t6_rst_count", count_o, 0);
    chk("t6_rst_err", err_o, 0);
    chk("t6_rst_no_done", done_cnt - d0, 0);
    rst_i = 1'b0;
    chk("t6_wr_left_after_rst", wr_q.size(), 0);
    push_wr(4'h1, 8'd6); push_wr(4'h0, 8'd1); push_wr(4'h0, 8'd2); push_wr(4'h0, 8'd3);
    run_q.push_back(1); run_q.push_back(1); run_q.push_back(1);
    d0 = done_cnt;
    start_sweep(8'd1, 8'd3, 8'd0, 8'd6, 8'd0, 8'd0);
    wait_idle(300);
    chk("t6_count", count_o, 3);
    chk("t6_cur", cur_o, 3);
    chk("t6_done_pulses", done_cnt - d0, 1);
    chk("t6_wr_left", wr_q.size(), 0);
    chk("t6_run_left", run_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
